// File: rtl/display_compositor_pkg.sv
// Shared constants and helpers for the display compositor: FSM encodings, brightness range,
// screen codes and the per-channel brightness scale.
package display_compositor_pkg;

  localparam int unsigned LVL_W = 5;
  localparam logic [LVL_W-1:0] LVL_MAX = 5'd16;

  localparam logic [1:0] CMP_SHOW     = 2'd0;
  localparam logic [1:0] CMP_FADE_OUT = 2'd1;
  localparam logic [1:0] CMP_FADE_IN  = 2'd2;

  // Same codes as the game FSM's START/PLAYING states, so req_sel can be driven from it.
  localparam int unsigned SCR_START   = 0;
  localparam int unsigned SCR_PLAYING = 1;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  function automatic logic [3:0] scale_chan(input logic [3:0] c, input logic [LVL_W-1:0] lvl);
    logic [8:0] prod;
    prod = {5'b0, c} * {4'b0, lvl};
    return 4'(prod >> 4);
  endfunction

endpackage

// File: rtl/display_compositor_rgb_scale.sv
// Combinational brightness scaler: each 4-bit channel becomes (c * lvl) >> 4.
module display_compositor_rgb_scale
  import display_compositor_pkg::*;
(
  input  logic [11:0]      pix,
  input  logic [LVL_W-1:0] lvl,
  output logic [11:0]      scaled
);

  rgb_t pix_s;

  assign pix_s  = pix;
  assign scaled = {scale_chan(pix_s.r, lvl), scale_chan(pix_s.g, lvl), scale_chan(pix_s.b, lvl)};

endmodule

// File: rtl/display_compositor.sv
// Screen compositor: frame-synchronous source switching with optional fade through black,
// and a two-strobe registered pixel path with matching sync delay.
module display_compositor
  import display_compositor_pkg::*;
#(
  parameter int unsigned N_SRC           = 2,
  parameter int unsigned SEL_W           = 2,
  parameter int unsigned RESET_SEL       = SCR_START,
  parameter bit          FADE_EN         = 1'b1,
  parameter int unsigned FRAMES_PER_STEP = 2,
  parameter bit          SYNC_IDLE       = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  input  logic               frame_start,
  input  logic               valid,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [SEL_W-1:0]   req_sel,
  input  logic [N_SRC*12-1:0] src_rgb,
  output logic [3:0]         vgaRed,
  output logic [3:0]         vgaGreen,
  output logic [3:0]         vgaBlue,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               busy
);

  localparam int unsigned N_SEL = 1 << SEL_W;
  localparam int unsigned CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [SEL_W-1:0] RST_SEL  = SEL_W'(RESET_SEL);
  localparam logic [SEL_W:0]   N_SRC_W  = (SEL_W + 1)'(N_SRC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

  logic [1:0]       state_q, state_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [SEL_W-1:0] cur_q, cur_d;
  logic [SEL_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_wrap;

  // Sources padded to a power of two so cur_q indexes without a width mismatch.
  logic [11:0] src_arr [N_SEL];

  for (genvar i = 0; i < N_SEL; i++) begin : g_src
    if (i < N_SRC) begin : g_used
      assign src_arr[i] = src_rgb[12*i +: 12];
    end else begin : g_pad
      assign src_arr[i] = '0;
    end
  end

  assign cnt_wrap = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    tgt_d   = ({1'b0, req_sel} < N_SRC_W) ? req_sel : tgt_q;
    if (frame_start) begin
      case (state_q)
        CMP_SHOW: begin
          if (tgt_q != cur_q) begin
            if (FADE_EN) begin
              state_d = CMP_FADE_OUT;
              cnt_d   = '0;
            end else begin
              cur_d = tgt_q;
            end
          end
        end
        CMP_FADE_OUT: begin
          if (tgt_q == cur_q) begin
            state_d = (lvl_q == LVL_MAX) ? CMP_SHOW : CMP_FADE_IN;
            cnt_d   = '0;
          end else if (cnt_wrap) begin
            cnt_d = '0;
            // lvl may already be 0 if a fade-in was reversed right after a switch.
            if (lvl_q <= 5'd1) begin
              lvl_d   = '0;
              cur_d   = tgt_q;
              state_d = CMP_FADE_IN;
            end else begin
              lvl_d = lvl_q - 5'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        CMP_FADE_IN: begin
          if (tgt_q != cur_q) begin
            state_d = CMP_FADE_OUT;
            cnt_d   = '0;
          end else if (cnt_wrap) begin
            cnt_d = '0;
            lvl_d = lvl_q + 5'd1;
            if (lvl_q >= LVL_MAX - 5'd1) begin
              lvl_d   = LVL_MAX;
              state_d = CMP_SHOW;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = CMP_SHOW;
          lvl_d   = LVL_MAX;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CMP_SHOW;
      lvl_q   <= LVL_MAX;
      cur_q   <= RST_SEL;
      tgt_q   <= RST_SEL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  logic [11:0] s1_rgb;
  logic        s1_valid, s1_hs, s1_vs;
  logic [11:0] s2_rgb;
  logic        s2_hs, s2_vs;
  logic [11:0] scaled;

  display_compositor_rgb_scale u_rgb_scale (
    .pix    (s1_rgb),
    .lvl    (lvl_q),
    .scaled (scaled)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_rgb   <= '0;
      s1_valid <= 1'b0;
      s1_hs    <= SYNC_IDLE;
      s1_vs    <= SYNC_IDLE;
      s2_rgb   <= '0;
      s2_hs    <= SYNC_IDLE;
      s2_vs    <= SYNC_IDLE;
    end else if (pix_en) begin
      s1_rgb   <= src_arr[cur_q];
      s1_valid <= valid;
      s1_hs    <= hsync_in;
      s1_vs    <= vsync_in;
      s2_rgb   <= s1_valid ? scaled : 12'h000;
      s2_hs    <= s1_hs;
      s2_vs    <= s1_vs;
    end
  end

  assign vgaRed    = s2_rgb[11:8];
  assign vgaGreen  = s2_rgb[7:4];
  assign vgaBlue   = s2_rgb[3:0];
  assign hsync_out = s2_hs;
  assign vsync_out = s2_vs;
  assign cur_sel   = cur_q;
  assign busy      = (state_q != CMP_SHOW) || (tgt_q != cur_q);

endmodule
